// File: rtl/pipeline_pkg.sv
// Shared types and constants for the RV32I pipeline front end.
package pipeline_pkg;

  localparam int          XLEN_DEF  = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Priority: flush (bubble) > stall (hold) > load > bubble.
module if_id_reg
  import pipeline_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            stall_i,
  input  logic            load_i,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  output logic [31:0]     instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic            valid_o
);

  logic [31:0]     instr_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_plus4_q;
  logic            valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q    <= NOP_INSTR;
      pc_q       <= '0;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
    end else if (flush_i) begin
      instr_q    <= NOP_INSTR;
      pc_q       <= '0;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
    end else if (stall_i) begin
      instr_q    <= instr_q;
      pc_q       <= pc_q;
      pc_plus4_q <= pc_plus4_q;
      valid_q    <= valid_q;
    end else if (load_i) begin
      instr_q    <= instr_i;
      pc_q       <= pc_i;
      pc_plus4_q <= pc_i + XLEN'(4);
      valid_q    <= 1'b1;
    end else begin
      // Nothing arrived this cycle: decode sees a bubble rather than a stall.
      instr_q    <= NOP_INSTR;
      pc_q       <= '0;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
    end
  end

  assign instr_o    = instr_q;
  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_plus4_q;
  assign valid_o    = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PCF, single-outstanding imem request FSM, skid buffer and the IF/ID register.
module fetch_stage
  import pipeline_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            StallF,
  input  logic            StallD,
  input  logic            FlushD,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic [31:0]     InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pcf_q, pcf_d;
  logic [XLEN-1:0] pend_pc_q, pend_pc_d;
  logic            kill_q, kill_d;
  logic [31:0]     buf_instr_q, buf_instr_d;

  logic            req_valid_c;
  logic            rsp_take;
  logic            ifid_load;
  logic [31:0]     ifid_instr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= REQ;
      pcf_q       <= RESET_PC;
      pend_pc_q   <= '0;
      kill_q      <= 1'b0;
      buf_instr_q <= NOP_INSTR;
    end else begin
      state_q     <= state_d;
      pcf_q       <= pcf_d;
      pend_pc_q   <= pend_pc_d;
      kill_q      <= kill_d;
      buf_instr_q <= buf_instr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pcf_d       = pcf_q;
    pend_pc_d   = pend_pc_q;
    kill_d      = kill_q;
    buf_instr_d = buf_instr_q;
    req_valid_c = 1'b0;
    rsp_take    = 1'b0;
    ifid_load   = 1'b0;
    ifid_instr  = imem_rsp_data;

    case (state_q)
      REQ: begin
        req_valid_c = !StallF && !PCSrcE;
        if (req_valid_c && imem_req_ready) begin
          pend_pc_d = pcf_q;
          pcf_d     = pcf_q + XLEN'(4);
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          rsp_take = 1'b1;
          state_d  = REQ;
          if (kill_q) begin
            kill_d = 1'b0;
          end else if (PCSrcE) begin
            kill_d = 1'b0;
          end else if (!StallD) begin
            ifid_load = 1'b1;
          end else begin
            buf_instr_d = imem_rsp_data;
            state_d     = HOLD;
          end
        end else if (PCSrcE) begin
          // Response still in flight belongs to the wrong path; drop it on arrival.
          kill_d = 1'b1;
        end
      end
      HOLD: begin
        ifid_instr = buf_instr_q;
        if (PCSrcE) begin
          state_d = REQ;
        end else if (!StallD) begin
          ifid_load = 1'b1;
          state_d   = REQ;
        end
      end
      default: state_d = REQ;
    endcase

    if (PCSrcE) begin
      pcf_d = PCTargetE;
    end
  end

  assign imem_req_valid = req_valid_c;
  assign imem_req_addr  = pcf_q;

  if_id_reg #(.XLEN(XLEN)) u_if_id (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (FlushD | PCSrcE),
    .stall_i    (StallD),
    .load_i     (ifid_load),
    .instr_i    (ifid_instr),
    .pc_i       (pend_pc_q),
    .instr_o    (InstrD),
    .pc_o       (PCD),
    .pc_plus4_o (PCPlus4D),
    .valid_o    (ValidD)
  );

`ifndef SYNTHESIS
  // A response seen outside WAIT (e.g. stale after reset) must never be consumed.
  stray_rsp_ignored: assert property (@(posedge clk) disable iff (!rst_n)
    (imem_rsp_valid && state_q != WAIT) |-> !rsp_take);
`endif

endmodule
